pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the single-issue core.
//  Holds the current PC and drives it to the PC adder (operand a, step on operand b).
//  Takes the adder's sum back as the sequential next PC, and issues one fetch at a time
//  to instruction memory with a valid/ready request and a valid-only response.
//  Presents the fetched {pc, instr} to decode with a valid/ready handshake; branch/jump
//  redirects from execute override sequential flow.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  PC_STEP       32'd4          constant driven on pc_step (adder operand b)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset, asynchronous, active-high
//  stall            in   1   hazard stall; blocks issue of new fetch requests
//  redirect_valid   in   1   load redirect_pc as the next fetch address
//  redirect_pc      in   32  branch/jump target
//  pc_out           out  32  current PC -> PC adder operand a
//  pc_step          out  32  PC_STEP -> PC adder operand b
//  pc_plus_step     in   32  PC adder sum (pc_out + pc_step)
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   imem accepts request
//  imem_req_addr    out  32  fetch address (= pc_out)
//  imem_resp_valid  in   1   read data valid (>=1 cycle after acceptance)
//  imem_resp_data   in   32  instruction word
//  if_valid         out  1   fetched instruction valid to decode
//  if_ready         in   1   decode accepts
//  if_pc            out  32  PC of presented instruction
//  if_instr         out  32  presented instruction
//  misaligned       out  1   sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): pc_out=RESET_VECTOR, state=FETCH, if_valid=0, if_pc=0,
//    if_instr=0, misaligned=0; imem_req_valid forced 0 while rst high. First request
//    issues the first clk edge after rst deasserts.
//  - imem_req_valid = (state==FETCH) & ~stall & ~rst (combinational); imem_req_addr = pc_out.
//  - States: FETCH, WAIT, HOLD, DRAIN (plus HALT with macro).
//  - FETCH: req_valid & req_ready -> WAIT. Stall only holds FETCH.
//  - WAIT: on resp_valid: if_pc<=pc_out, if_instr<=resp_data, if_valid<=1 -> HOLD.
//  - HOLD: if_valid & if_ready: if_valid<=0, pc_out<=pc_plus_step -> FETCH.
//    if_pc/if_instr stable while if_valid & ~if_ready.
//  - Throughput: max one instruction per 3 cycles (zero-wait imem, if_ready=1).
//  - Redirect (highest priority, overrides stall; pc_out<=redirect_pc, if_valid<=0):
//    - in FETCH without handshake, or in HOLD -> FETCH.
//    - in FETCH with req handshake the same cycle -> DRAIN (old request in flight).
//    - in WAIT with no resp this cycle -> DRAIN; WAIT with resp the same cycle:
//      discard response -> FETCH.
//    - in DRAIN -> DRAIN (pc updated; one response still owed).
//  - DRAIN: next resp_valid discarded (no if_valid) -> FETCH.
//  - resp_valid in FETCH/HOLD is spurious: ignored, no state change.
//  - pc_out wraps 32'hFFFF_FFFC -> 0 via the adder's modulo-2^32 sum; no special case.
//  - pc_step = PC_STEP constant at all times, including reset.
// CONFIGURATION
//  - PC_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 still loads pc_out
//    and sets misaligned<=1 -> HALT (DRAIN first if a response is owed).
//    - HALT: no requests, if_valid=0.
//    - Exit HALT only via reset or an aligned redirect, which also clears misaligned.
//  - Undefined: redirect_pc[1:0] forced to 2'b00 on load; misaligned tied 0.
// TESTING
//  1. Reset release, imem 1-cycle latency, if_ready=1 -> requests at 0x0,0x4,0x8,
//     one per 3 cycles; if_pc matches.
//  2. if_ready=0 for 5 cycles in HOLD -> if_pc/if_instr stable, no new request; pc
//     advances only at handshake.
//  3. Redirect to 0x100 one cycle after accepted request, 3-cycle resp latency ->
//     response dropped; next request addr 0x100.
//  4. stall=1 in FETCH for 4 cycles, then redirect=0x40 while stalled -> no request
//     until stall drops; then addr 0x40.
//  5. pc_out=0xFFFF_FFFC, handshake -> next request addr 0x0.
//  6. Macro on: redirect to 0x102 -> misaligned=1, no requests; redirect 0x200 ->
//     flag clears, fetch 0x200. Macro off: same stimulus fetches 0x100.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer with redirect support.
// Optional build macro PC_MISALIGN_TRAP_EN: misaligned redirects raise a sticky flag and halt fetch.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] pc_step,
    input  logic [31:0] pc_plus_step,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misaligned
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] redir_pc;
    logic        redir_bad;
    logic [2:0]  redir_next;
    logic        req_fire;

`ifdef PC_MISALIGN_TRAP_EN
    assign redir_pc  = redirect_pc;
    assign redir_bad = |redirect_pc[1:0];
`else
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^redirect_pc[1:0];
    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    assign redir_next     = redir_bad ? S_HALT : S_FETCH;
    assign imem_req_valid = (state_q == S_FETCH) & ~stall & ~rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign pc_out     = pc_q;
    assign pc_step    = PC_STEP;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;
    assign misaligned = misaligned_q;

    // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        misaligned_d = misaligned_q;

        if (redirect_valid) begin
            pc_d         = redir_pc;
            if_valid_d   = 1'b0;
            misaligned_d = redir_bad;
            // A request already in flight must have its response swallowed in DRAIN.
            case (state_q)
                S_FETCH:         state_d = req_fire ? S_DRAIN : redir_next;
                S_WAIT, S_DRAIN: state_d = imem_resp_valid ? redir_next : S_DRAIN;
                default:         state_d = redir_next;
            endcase
        end else begin
            case (state_q)
                S_FETCH: if (req_fire) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_resp_data;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        pc_d       = pc_plus_step;
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: if (imem_resp_valid) state_d = misaligned_q ? S_HALT : S_FETCH;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a transaction-level imem/decode model predicts every output.
// Honours PC_MISALIGN_TRAP_EN when it is defined for the build.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, pc_step, pc_plus_step;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc, if_instr;
    logic        misaligned;

    pc_fetch_unit #(.RESET_VECTOR(RESET_VECTOR), .PC_STEP(PC_STEP)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .pc_step(pc_step), .pc_plus_step(pc_plus_step),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .misaligned(misaligned)
    );

    // External PC adder
    assign pc_plus_step = pc_out + pc_step;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Architectural model: next fetch address, presented instruction, trap flag
    logic [31:0] m_pc;
    bit          m_show, m_halt, m_mis;
    logic [31:0] m_show_pc, m_show_instr;

    // One outstanding imem transaction at most
    bit          tk_live, tk_dead;
    logic [31:0] tk_addr, tk_data;
    int          tk_cnt;

    // Stimulus knobs (percent) and a one-shot forced redirect
    int p_stall, p_redir, p_ready, p_req_ready, p_spur, lat_max;
    bit          f_redir = 1'b0;
    logic [31:0] f_pc = 32'h0;

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic knobs(input int st, input int rd, input int rdy, input int rrdy,
                         input int sp, input int lat);
        p_stall = st; p_redir = rd; p_ready = rdy; p_req_ready = rrdy;
        p_spur = sp; lat_max = lat;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
        if_ready = 1'b0; imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_pc = RESET_VECTOR; m_show = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
        tk_live = 1'b0; tk_dead = 1'b0;
        check("rst_pc_out", pc_out, RESET_VECTOR);
        check("rst_pc_step", pc_step, PC_STEP);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Drives one cycle at a negedge, checks outputs, then advances the model past the next posedge.
    task automatic do_cycle();
        bit          resp_real, e_req, fire;
        logic [31:0] req_pc;
        resp_real = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (tk_live) begin
            tk_cnt--;
            if (tk_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = tk_data;
                resp_real       = 1'b1;
            end
        end else if ($urandom_range(99, 0) < p_spur) begin
            imem_resp_valid = 1'b1;
        end
        stall          = ($urandom_range(99, 0) < p_stall);
        imem_req_ready = ($urandom_range(99, 0) < p_req_ready);
        if_ready       = ($urandom_range(99, 0) < p_ready);
        if (f_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = f_pc;
            f_redir        = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99, 0) < p_redir);
            redirect_pc    = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
        end
        #1;
        e_req = !stall && !tk_live && !m_show && !m_halt;
        check("pc_out", pc_out, m_pc);
        check("pc_step", pc_step, PC_STEP);
        check("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) check("req_addr", imem_req_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_show));
        if (m_show) begin
            check("if_pc", if_pc, m_show_pc);
            check("if_instr", if_instr, m_show_instr);
        end
        check("misaligned", 32'(misaligned), 32'(m_mis));

        fire   = e_req && imem_req_ready;
        req_pc = m_pc;
        if (redirect_valid) begin
            m_show = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            m_pc   = redirect_pc;
            m_mis  = (redirect_pc[1:0] != 2'b00);
            m_halt = m_mis;
`else
            m_pc   = redirect_pc & ~32'h3;
`endif
        end else if (resp_real && !tk_dead) begin
            m_show       = 1'b1;
            m_show_pc    = tk_addr;
            m_show_instr = tk_data;
        end else if (m_show && if_ready) begin
            m_show = 1'b0;
            m_pc   = m_show_pc + PC_STEP;
        end
        if (resp_real) tk_live = 1'b0;
        if (tk_live && redirect_valid) tk_dead = 1'b1;
        if (fire) begin
            tk_live = 1'b1;
            tk_dead = redirect_valid;
            tk_addr = req_pc;
            tk_data = $urandom;
            tk_cnt  = $urandom_range(lat_max, 1);
            acc_addr.push_back(req_pc);
            acc_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic forced_redirect(input logic [31:0] target);
        f_redir = 1'b1;
        f_pc    = target;
        do_cycle();
        acc_addr.delete();
        acc_cyc.delete();
    endtask

    initial begin
        knobs(0, 0, 100, 100, 0, 1);
        do_reset();

        // Sequential fetch from reset: 0x0, 0x4, 0x8 one per three cycles
        acc_addr.delete(); acc_cyc.delete();
        run(10);
        check("seq_count_ge3", 32'(acc_addr.size() >= 3), 32'd1);
        if (acc_addr.size() >= 3) begin
            check("seq_addr0", acc_addr[0], 32'h0);
            check("seq_addr1", acc_addr[1], 32'h4);
            check("seq_addr2", acc_addr[2], 32'h8);
            check("seq_first_cyc", 32'(acc_cyc[0]), 32'd0);
            check("seq_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("seq_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        // PC wraps through the adder
        forced_redirect(32'hFFFF_FFFC);
        run(12);
        check("wrap_count_ge2", 32'(acc_addr.size() >= 2), 32'd1);
        if (acc_addr.size() >= 2) begin
            check("wrap_addr0", acc_addr[0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc_addr[1], 32'h0);
        end

        // Misaligned redirect target
        forced_redirect(32'h0000_0102);
        run(9);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_no_fetch", 32'(acc_addr.size()), 32'd0);
        check("mis_flag_set", 32'(misaligned), 32'd1);
        forced_redirect(32'h0000_0200);
        run(9);
        check("mis_flag_clear", 32'(misaligned), 32'd0);
        check("mis_refetch_any", 32'(acc_addr.size() >= 1), 32'd1);
        if (acc_addr.size() >= 1) check("mis_refetch_addr", acc_addr[0], 32'h200);
`else
        check("mis_fetch_any", 32'(acc_addr.size() >= 1), 32'd1);
        if (acc_addr.size() >= 1) check("mis_fetch_addr", acc_addr[0], 32'h100);
        check("mis_flag_zero", 32'(misaligned), 32'd0);
`endif

        // Random traffic: stalls, back-pressure, variable latency, spurious responses, redirects
        knobs(20, 8, 60, 60, 10, 4);
        run(4000);

        // Asynchronous reset mid-run, then more random traffic
        do_reset();
        knobs(15, 5, 70, 70, 5, 3);
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
